// File: rtl/inst_mem_burst_responder_pkg.sv
// Shared definitions for the instruction-cache block-fill memory interface.
package inst_mem_burst_responder_pkg;

  localparam int unsigned DEF_DATA_WIDTH         = 32;
  localparam int unsigned DEF_ADDR_WIDTH         = 20;
  localparam int unsigned DEF_BLOCK_OFFSET_WIDTH = 9;
  localparam int unsigned DEF_MEM_ADDR_WIDTH     = 12;
  localparam int unsigned DEF_FIRST_LATENCY      = 2;

  // Holds FIRST_LATENCY-1 for latencies up to 15.
  localparam int unsigned WAIT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_WAIT  = 2'd1,
    STATE_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/inst_mem_burst_responder_mem_array.sv
// Backing word array: one write port, one registered read port, read-before-write.
module burst_mem_array
  import inst_mem_burst_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so a preloaded program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; a same-edge write is not yet visible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem_burst_responder.sv
// Memory-side responder for cache block fills: latches a block address and streams
// the block back one word per cycle after a fixed first-word latency.
module inst_mem_burst_responder
  import inst_mem_burst_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int unsigned BLOCK_OFFSET_WIDTH = DEF_BLOCK_OFFSET_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH     = DEF_MEM_ADDR_WIDTH,
  parameter int unsigned FIRST_LATENCY      = DEF_FIRST_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  output logic                      resp_valid,
  output logic                      resp_last,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      busy,
  input  logic                      load_en,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]     load_data
);

  localparam int unsigned BASE_WIDTH = MEM_ADDR_WIDTH - BLOCK_OFFSET_WIDTH;
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_INIT =
    WAIT_CNT_WIDTH'(FIRST_LATENCY - 1);
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] BEAT_LAST = '1;

  state_t                        state, state_next;
  logic [BASE_WIDTH-1:0]         base, base_next;
  logic [WAIT_CNT_WIDTH-1:0]     wait_cnt, wait_next;
  logic [BLOCK_OFFSET_WIDTH-1:0] beat_cnt, beat_next;
  logic                          valid_next, last_next;
  logic                          rd_en;
  logic [MEM_ADDR_WIDTH-1:0]     rd_addr;

  assign rd_addr = {base, beat_cnt};
  assign busy    = (state != STATE_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STATE_IDLE;
      base       <= '0;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
    end else begin
      state      <= state_next;
      base       <= base_next;
      wait_cnt   <= wait_next;
      beat_cnt   <= beat_next;
      resp_valid <= valid_next;
      resp_last  <= last_next;
    end
  end

  // Beat 0 is read on the final WAIT edge so the registered array output lands
  // exactly FIRST_LATENCY edges after acceptance; BURST then handles beats 1..N-1
  // (or all beats when FIRST_LATENCY is 1) and one closing edge after resp_last.
  always_comb begin
    state_next = state;
    base_next  = base;
    wait_next  = wait_cnt;
    beat_next  = beat_cnt;
    valid_next = 1'b0;
    last_next  = 1'b0;
    rd_en      = 1'b0;

    case (state)
      STATE_IDLE: begin
        if (req_valid) begin
          base_next  = req_addr[MEM_ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
          wait_next  = WAIT_INIT;
          beat_next  = '0;
          state_next = (FIRST_LATENCY == 1) ? STATE_BURST : STATE_WAIT;
        end
      end

      STATE_WAIT: begin
        if (!req_valid) begin
          state_next = STATE_IDLE;
        end else if (wait_cnt == '0) begin
          rd_en      = 1'b1;
          valid_next = 1'b1;
          last_next  = (beat_cnt == BEAT_LAST);
          beat_next  = beat_cnt + 1'b1;
          state_next = STATE_BURST;
        end else begin
          wait_next = wait_cnt - 1'b1;
        end
      end

      STATE_BURST: begin
        if (!req_valid || resp_last) begin
          state_next = STATE_IDLE;
        end else begin
          rd_en      = 1'b1;
          valid_next = 1'b1;
          last_next  = (beat_cnt == BEAT_LAST);
          beat_next  = beat_cnt + 1'b1;
        end
      end

      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  burst_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (load_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(resp_data)
  );

endmodule

// File: tb/tb_inst_mem_burst_responder.sv
// Bench for inst_mem_burst_responder: three instances (latency 1, 2, 5) driven one at a
// time; expected beats are queued at issue and checked by an independent monitor.
module tb_inst_mem_burst_responder;

  localparam int DW    = 32;
  localparam int AW    = 20;
  localparam int BOW   = 2;
  localparam int MAW   = 6;
  localparam int NI    = 3;
  localparam int BEATS = 4;
  localparam int WORDS = 64;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] req_valid, resp_valid, resp_last, busy, load_en;
  logic [AW-1:0]  req_addr  [NI];
  logic [DW-1:0]  resp_data [NI];
  logic [MAW-1:0] load_addr [NI];
  logic [DW-1:0]  load_data [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inst_mem_burst_responder #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .BLOCK_OFFSET_WIDTH(BOW),
      .MEM_ADDR_WIDTH(MAW),
      .FIRST_LATENCY(lat_of(g))
    ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid[g]),
      .req_addr(req_addr[g]),
      .resp_valid(resp_valid[g]),
      .resp_last(resp_last[g]),
      .resp_data(resp_data[g]),
      .busy(busy[g]),
      .load_en(load_en[g]),
      .load_addr(load_addr[g]),
      .load_data(load_data[g])
    );
  end

  // kind: 0 = beat, 1 = busy level, 2 = resp_data value
  typedef struct {
    int          inst;
    int          cyc;
    int          kind;
    logic [31:0] val;
    logic        last;
  } exp_t;

  exp_t beat_q[$];
  exp_t side_q[$];
  logic [DW-1:0] model [NI][WORDS];

  int checks = 0;
  int failures = 0;
  bit finishing = 1'b0;
  bit final_done = 1'b0;

  task automatic push_side(input int inst, input int c, input int kind, input logic [31:0] v);
    exp_t e;
    e.inst = inst; e.cyc = c; e.kind = kind; e.val = v; e.last = 1'b0;
    side_q.push_back(e);
  endtask

  // Issue one fill. nbeats<4 aborts after that many beats; ld_rel>0 writes ld_a at edge k+ld_rel.
  task automatic do_burst(input int inst, input logic [AW-1:0] addr, input int nbeats,
                          input int ld_rel, input logic [MAW-1:0] ld_a,
                          input logic [DW-1:0] ld_d, input bit keep_high);
    int k, lat, end_c;
    logic [3:0] base;
    logic [MAW-1:0] word;
    exp_t e;
    k = cyc + 1;
    lat = lat_of(inst);
    base = addr[MAW-1:BOW];
    req_valid[inst] = 1'b1;
    req_addr[inst] = addr;
    for (int i = 0; i < nbeats; i++) begin
      word = {base, 2'(i)};
      e.inst = inst; e.cyc = k + lat + i; e.kind = 0; e.last = (i == BEATS - 1);
      e.val = model[inst][word];
      if (ld_rel > 0 && ld_a == word && ld_rel < lat + i) e.val = ld_d;
      beat_q.push_back(e);
    end
    if (ld_rel > 0) model[inst][ld_a] = ld_d;
    end_c = k + lat + nbeats - 1;
    push_side(inst, k, 1, 32'd1);
    push_side(inst, end_c + 1, 1, 32'd0);
    for (int t = k; t <= end_c + 1; t++) begin
      @(negedge clk);
      load_en[inst] = 1'b0;
      if (ld_rel > 0 && t == k + ld_rel - 1) begin
        load_en[inst] = 1'b1;
        load_addr[inst] = ld_a;
        load_data[inst] = ld_d;
      end
      if (t == k) req_addr[inst] = 20'($urandom);
      if (t == end_c && !(keep_high && nbeats == BEATS)) req_valid[inst] = 1'b0;
    end
  endtask

  task automatic reset_mid_wait();
    int k;
    k = cyc + 1;
    req_valid[2] = 1'b1;
    req_addr[2] = 20'h00008;
    push_side(2, k, 1, 32'd1);
    push_side(2, k + 1, 1, 32'd0);
    push_side(2, k + 1, 2, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid[2] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
      e = beat_q.pop_front();
      checks++; failures++;
      $display("FAIL missing_beat inst=%0d cycle=%0d: no beat seen, required data=%h last=%b",
               e.inst, e.cyc, e.val, e.last);
    end
    for (int i = 0; i < NI; i++) begin
      if (resp_valid[i] === 1'b1) begin
        checks++;
        if (beat_q.size() == 0 || beat_q[0].inst != i || beat_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL beat_timing inst=%0d cycle=%0d: got beat data=%h, required no beat",
                   i, cyc, resp_data[i]);
        end else begin
          e = beat_q.pop_front();
          if (resp_data[i] !== e.val || resp_last[i] !== e.last) begin
            failures++;
            $display("FAIL beat_data inst=%0d cycle=%0d: got data=%h last=%b, required data=%h last=%b",
                     i, cyc, resp_data[i], resp_last[i], e.val, e.last);
          end
        end
      end else if (resp_valid[i] !== 1'b0 || resp_last[i] !== 1'b0) begin
        checks++; failures++;
        $display("FAIL idle_outputs inst=%0d cycle=%0d: got valid=%b last=%b, required 0 0",
                 i, cyc, resp_valid[i], resp_last[i]);
      end
    end
    while (side_q.size() > 0 && side_q[0].cyc <= cyc) begin
      e = side_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL side_check_expired inst=%0d cycle=%0d kind=%0d", e.inst, e.cyc, e.kind);
      end else if (e.kind == 1 && busy[e.inst] !== e.val[0]) begin
        failures++;
        $display("FAIL busy inst=%0d cycle=%0d: got %b, required %b", e.inst, cyc, busy[e.inst], e.val[0]);
      end else if (e.kind == 2 && resp_data[e.inst] !== e.val) begin
        failures++;
        $display("FAIL reset_data inst=%0d cycle=%0d: got %h, required %h", e.inst, cyc, resp_data[e.inst], e.val);
      end
    end
    if (finishing && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (beat_q.size() != 0 || side_q.size() != 0) begin
        failures++;
        $display("FAIL leftover_expectations: got %0d beats %0d side checks pending, required 0 0",
                 beat_q.size(), side_q.size());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int inst, nb, nbeats, ld_rel, lat;
    bit keep;
    logic [AW-1:0] addr;
    logic [MAW-1:0] ld_a;

    rst = 1'b1;
    req_valid = '0;
    load_en = '0;
    for (int i = 0; i < NI; i++) begin
      req_addr[i] = '0; load_addr[i] = '0; load_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      push_side(i, cyc + 1, 1, 32'd0);
      push_side(i, cyc + 1, 2, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < WORDS; w++) begin
      for (int i = 0; i < NI; i++) begin
        load_en[i] = 1'b1;
        load_addr[i] = 6'(w);
        load_data[i] = 32'h1000 + 32'(w);
        model[i][w] = 32'h1000 + 32'(w);
      end
      @(negedge clk);
    end
    load_en = '0;
    @(negedge clk);

    do_burst(1, 20'h00008, BEATS, 0, '0, '0, 1'b0);
    do_burst(1, 20'h0004B, BEATS, 0, '0, '0, 1'b0);
    do_burst(0, 20'h00008, BEATS, 0, '0, '0, 1'b1);
    do_burst(0, 20'h00010, BEATS, 0, '0, '0, 1'b0);
    do_burst(2, 20'h00008, BEATS, 0, '0, '0, 1'b0);
    do_burst(2, 20'h00010, BEATS, 0, '0, '0, 1'b0);
    do_burst(1, 20'h00008, 2, 0, '0, '0, 1'b0);
    reset_mid_wait();
    do_burst(2, 20'h00008, BEATS, 0, '0, '0, 1'b0);
    do_burst(1, 20'h00008, BEATS, 1, 6'h09, 32'h0000DEAD, 1'b0);
    do_burst(1, 20'h00008, BEATS, 2, 6'h08, 32'h0000BEEF, 1'b0);
    do_burst(1, 20'h00008, BEATS, 0, '0, '0, 1'b0);

    for (int grp = 0; grp < 14; grp++) begin
      inst = $urandom_range(0, NI - 1);
      lat = lat_of(inst);
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        addr = 20'($urandom);
        nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : BEATS;
        ld_rel = 0;
        ld_a = 6'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          ld_rel = $urandom_range(1, lat + nbeats - 1);
          if ($urandom_range(0, 1) == 1) ld_a = {addr[MAW-1:BOW], 2'($urandom)};
        end
        keep = (j < nb - 1) && (nbeats == BEATS) && ($urandom_range(0, 1) == 1);
        do_burst(inst, addr, nbeats, ld_rel, ld_a, 32'($urandom), keep);
      end
    end

    repeat (10) @(negedge clk);
    finishing = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
